// File: rtl/irq_pending_unit.sv
// irq_pending_unit: synchronises interrupt request lines, detects edges or
// levels per line, holds pending bits, applies the enable mask towards the
// daisy chain and records lost edges in sticky overflow flags.
module irq_pending_unit #(
    parameter int unsigned N_IRQ       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_IRQ-1:0] irq_req_i,
    input  logic [N_IRQ-1:0] irq_edge_mode_i,
    input  logic [N_IRQ-1:0] mie_i,
    input  logic [N_IRQ-1:0] irq_ret_i,
    input  logic [N_IRQ-1:0] ovf_clr_i,
    output logic [N_IRQ-1:0] masked_irq_o,
    output logic [N_IRQ-1:0] pending_o,
    output logic [N_IRQ-1:0] overflow_o
);

    logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [N_IRQ-1:0] sync_d [SYNC_STAGES];
    logic [N_IRQ-1:0] prev_q;
    logic [N_IRQ-1:0] prev_d;
    logic [N_IRQ-1:0] pending_q;
    logic [N_IRQ-1:0] pending_d;
    logic [N_IRQ-1:0] overflow_q;
    logic [N_IRQ-1:0] overflow_d;
    logic [N_IRQ-1:0] sync;
    logic [N_IRQ-1:0] rise;

    // Synchroniser shift chain and edge-detect history
    always_comb begin
        sync_d[0] = irq_req_i;
        for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        sync   = sync_q[SYNC_STAGES-1];
        prev_d = sync;
        rise   = sync & ~prev_q;
    end

    // Pending and overflow next state; a new edge beats a same-cycle clear
    always_comb begin
        pending_d  = (irq_edge_mode_i & (rise | (pending_q & ~irq_ret_i)))
                   | (~irq_edge_mode_i & sync);
        overflow_d = (overflow_q & ~ovf_clr_i)
                   | (irq_edge_mode_i & rise & pending_q & ~irq_ret_i);
    end

    // All state registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q     <= '0;
            pending_q  <= '0;
            overflow_q <= '0;
        end else begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            prev_q     <= prev_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    // Mask is applied combinationally so mie_i changes act without delay
    always_comb begin
        masked_irq_o = pending_q & mie_i;
        pending_o    = pending_q;
        overflow_o   = overflow_q;
    end

endmodule

// File: tb/tb_irq_pending_unit.sv
// Scoreboard bench for irq_pending_unit: expectations are queued with the
// cycle at which they are due and compared #1 after that rising edge.
module tb_irq_pending_unit;

    localparam int unsigned N = 16;

    logic         clk = 1'b0;
    logic         rst_i;
    logic [N-1:0] req, mode, mie, ret, clr;
    logic [N-1:0] masked, pend, ovf;

    typedef struct {
        int           cyc;
        string        tag;
        logic [N-1:0] pend;
        logic [N-1:0] ovf;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    irq_pending_unit #(.N_IRQ(N), .SYNC_STAGES(2)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .irq_req_i      (req),
        .irq_edge_mode_i(mode),
        .mie_i          (mie),
        .irq_ret_i      (ret),
        .ovf_clr_i      (clr),
        .masked_irq_o   (masked),
        .pending_o      (pend),
        .overflow_o     (ovf)
    );

    // Single comparison point: counts and reports mismatches
    task automatic check_val(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic push(input int dly, input string tag, input logic [N-1:0] p, input logic [N-1:0] o);
        exp_t e;
        e.cyc  = cyc + dly;
        e.tag  = tag;
        e.pend = p;
        e.ovf  = o;
        sb.push_back(e);
    endtask

    task automatic check_due();
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check_val({sb[i].tag, "_pend"}, pend, sb[i].pend);
                check_val({sb[i].tag, "_mask"}, masked, sb[i].pend & mie);
                check_val({sb[i].tag, "_ovf"}, ovf, sb[i].ovf);
                sb.delete(i);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        check_due();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // One-cycle request pulse
    task automatic pulse(input logic [N-1:0] m);
        req = m;
        step();
        req = '0;
    endtask

    initial begin
        rst_i = 1'b0;
        req   = '0;
        mode  = 16'hFFFF;
        mie   = 16'hFFFF;
        ret   = '0;
        clr   = '0;
        run(2);
        check_val("rst_pend", pend, 16'h0000);
        check_val("rst_mask", masked, 16'h0000);
        check_val("rst_ovf", ovf, 16'h0000);
        rst_i = 1'b1;
        run(2);

        // Edge capture on line 3 with latency check, then return clears it
        push(2, "e3_early", 16'h0000, 16'h0000);
        push(3, "e3_set", 16'h0008, 16'h0000);
        pulse(16'h0008);
        run(2);
        ret = 16'h0008;
        push(1, "e3_ret", 16'h0000, 16'h0000);
        step();
        ret = '0;
        run(2);

        // Masked pending bit is held and shows up as soon as mie rises
        mie = 16'h0000;
        push(3, "m5_hold", 16'h0020, 16'h0000);
        pulse(16'h0020);
        run(3);
        mie = 16'h0020;
        #1;
        check_val("m5_unmask", masked, 16'h0020);
        mie = 16'hFFFF;
        ret = 16'h0020;
        push(1, "m5_ret", 16'h0000, 16'h0000);
        step();
        ret = '0;
        run(2);

        // Line 7: return coincides with a new edge, set wins, no overflow
        push(3, "s7_first", 16'h0080, 16'h0000);
        pulse(16'h0080);
        run(2);
        pulse(16'h0080);
        step();
        ret = 16'h0080;
        push(1, "s7_setwins", 16'h0080, 16'h0000);
        step();
        push(1, "s7_clear", 16'h0000, 16'h0000);
        step();
        ret = '0;
        run(2);

        // Line 2: second edge while pending sets sticky overflow
        push(3, "o2_first", 16'h0004, 16'h0000);
        pulse(16'h0004);
        run(2);
        push(2, "o2_noyet", 16'h0004, 16'h0000);
        push(3, "o2_set", 16'h0004, 16'h0004);
        pulse(16'h0004);
        run(2);
        push(3, "o2_sticky", 16'h0004, 16'h0004);
        run(3);
        clr = 16'h0004;
        push(1, "o2_clr", 16'h0004, 16'h0000);
        step();
        clr = '0;
        ret = 16'h0004;
        push(1, "o2_ret", 16'h0000, 16'h0000);
        step();
        ret = '0;
        run(2);

        // Line 9 level mode: follows the line, returns are ignored
        mode = 16'hFDFF;
        step();
        push(2, "l9_early", 16'h0000, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            req = 16'h0200;
            ret = (i % 3 == 1) ? 16'h0200 : 16'h0000;
            if (i >= 2) push(1, "l9_high", 16'h0200, 16'h0000);
            step();
        end
        req = '0;
        ret = '0;
        push(2, "l9_lag", 16'h0200, 16'h0000);
        push(3, "l9_drop", 16'h0000, 16'h0000);
        run(4);
        mode = 16'hFFFF;
        run(2);

        // Reset mid-operation with lines 0..7 still high afterwards
        push(3, "r_allpend", 16'hFFFF, 16'h0000);
        pulse(16'hFFFF);
        run(2);
        req = 16'h00FF;
        push(3, "r_ovf", 16'hFFFF, 16'h00FF);
        run(3);
        rst_i = 1'b0;
        push(1, "r_cleared", 16'h0000, 16'h0000);
        step();
        rst_i = 1'b1;
        push(2, "r_lag", 16'h0000, 16'h0000);
        push(3, "r_fresh", 16'h00FF, 16'h0000);
        run(3);
        req = '0;
        ret = 16'h00FF;
        push(1, "r_ret", 16'h0000, 16'h0000);
        step();
        ret = '0;
        run(2);

        check_val("sb_left", N'(sb.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
